// File: rtl/io_input_conditioner.sv
// Board switch/key front end: 2-flop synchronizers, per-key debounce FSMs with
// press pulses and sticky pending flags, and a shared-counter switch debouncer.
module io_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] sw_raw,
  input  logic [3:0]  key_n_raw,
  input  logic [3:0]  key_ack,
  output logic [17:0] sw_stable,
  output logic        sw_changed,
  output logic [3:0]  key_level,
  output logic [3:0]  key_pulse,
  output logic [3:0]  key_pending
);

  localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } key_state_e;

  logic [17:0] sw_sync1_q, sw_sync2_q;
  logic [3:0]  key_sync1_q, key_sync2_q;
  logic [3:0]  key_pressed;

  key_state_e  state_q [4];
  key_state_e  state_d [4];
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [3:0]  pulse_q, pulse_d;
  logic [3:0]  pending_q, pending_d;

  logic [17:0] sw_cap_q, sw_cap_d;
  logic [17:0] sw_stable_q, sw_stable_d;
  logic [15:0] sw_cnt_q, sw_cnt_d;
  logic        sw_changed_q, sw_changed_d;

  // Raw keys are active-low, so their synchronizers reset to 1 (released).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      key_sync1_q <= '1;
      key_sync2_q <= '1;
    end else begin
      sw_sync1_q  <= sw_raw;
      sw_sync2_q  <= sw_sync1_q;
      key_sync1_q <= key_n_raw;
      key_sync2_q <= key_sync1_q;
    end
  end

  assign key_pressed = ~key_sync2_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      unique case (state_q[i])
        StReleased: begin
          if (key_pressed[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = '0;
          end
        end
        StPressWait: begin
          if (!key_pressed[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] < CntLast) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end else begin
            state_d[i] = StPressed;
            pulse_d[i] = 1'b1;
          end
        end
        StPressed: begin
          if (!key_pressed[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end
        end
        StReleaseWait: begin
          if (key_pressed[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] < CntLast) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end else begin
            state_d[i] = StReleased;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // A new press sets pending even if the CPU acknowledges in the same cycle.
  assign pending_d = pulse_q | (pending_q & ~key_ack);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
      pulse_q   <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    sw_cap_d     = sw_cap_q;
    sw_cnt_d     = sw_cnt_q;
    sw_stable_d  = sw_stable_q;
    sw_changed_d = 1'b0;
    if (sw_sync2_q != sw_cap_q) begin
      sw_cap_d = sw_sync2_q;
      sw_cnt_d = '0;
    end else if (sw_cnt_q < CntLast) begin
      sw_cnt_d = sw_cnt_q + 16'd1;
    end else begin
      sw_stable_d  = sw_cap_q;
      sw_changed_d = (sw_cap_q != sw_stable_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_cap_q     <= '0;
      sw_cnt_q     <= '0;
      sw_stable_q  <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_cap_q     <= sw_cap_d;
      sw_cnt_q     <= sw_cnt_d;
      sw_stable_q  <= sw_stable_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      key_level[i] = (state_q[i] == StPressed) || (state_q[i] == StReleaseWait);
    end
  end

  assign key_pulse   = pulse_q;
  assign key_pending = pending_q;
  assign sw_stable   = sw_stable_q;
  assign sw_changed  = sw_changed_q;

endmodule
